// File: rtl/instr_receiver.sv
// rtl/instr_receiver.sv - HPS PIO instruction receiver: toggle handshake, decode, issue to filter core, status report
module instr_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  output logic [31:0] status_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [3:0]  cmd_param,
  output logic [14:0] cmd_addr,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_error
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_COMPLETE
  } state_t;

  state_t      state_q, state_d;
  logic [30:0] instr_q, instr_d;
  logic        last_tog_q, last_tog_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        st_err_q, st_err_d;
  logic [7:0]  st_res_q, st_res_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  result_q, result_d;
  logic        error_q, error_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [1:0]  cmd_op_q, cmd_op_d;
  logic [3:0]  cmd_param_q, cmd_param_d;
  logic [14:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] tmo_inc;

  assign tmo_inc = tmo_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    last_tog_d  = last_tog_q;
    busy_d      = busy_q;
    ack_d       = ack_q;
    st_err_d    = st_err_q;
    st_res_d    = st_res_q;
    count_d     = count_q;
    result_d    = result_q;
    error_d     = error_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_param_d = cmd_param_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    tmo_d       = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (instr_in[31] != last_tog_q) begin
          instr_d    = instr_in[30:0];
          last_tog_d = instr_in[31];
          busy_d     = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        case (instr_q[30:27])
          4'd0: begin
            result_d = 8'h00;
            error_d  = 1'b0;
            state_d  = S_COMPLETE;
          end
          4'd1, 4'd2, 4'd3: begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = instr_q[28:27];
            cmd_param_d = instr_q[26:23];
            cmd_addr_d  = instr_q[22:8];
            cmd_data_d  = instr_q[7:0];
            state_d     = S_ISSUE;
          end
          default: begin
            result_d = 8'h00;
            error_d  = 1'b1;
            state_d  = S_COMPLETE;
          end
        endcase
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          tmo_d       = 16'd0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving in the final counted cycle beats the timeout.
        if (rsp_valid) begin
          result_d = rsp_data;
          error_d  = rsp_error;
          state_d  = S_COMPLETE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            result_d = 8'hFF;
            error_d  = 1'b1;
            state_d  = S_COMPLETE;
          end
        end
      end
      S_COMPLETE: begin
        ack_d    = last_tog_q;
        st_err_d = error_q;
        st_res_d = result_q;
        count_d  = count_q + 8'd1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      last_tog_q  <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      st_err_q    <= 1'b0;
      st_res_q    <= '0;
      count_q     <= '0;
      result_q    <= '0;
      error_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_param_q <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      last_tog_q  <= last_tog_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      st_err_q    <= st_err_d;
      st_res_q    <= st_res_d;
      count_q     <= count_d;
      result_q    <= result_d;
      error_q     <= error_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_param_q <= cmd_param_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      tmo_q       <= tmo_d;
    end
  end

  assign status_out = {ack_q, st_err_q, busy_q, 5'b0, count_q, 8'b0, st_res_q};
  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_param  = cmd_param_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_data   = cmd_data_q;

endmodule

// File: doc/instr_receiver.md
INSTR_RECEIVER -- requirements
Module: instr_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning max cycles waited in WAIT for rsp_valid (1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port instr_in  input  32  instruction word from HPS output PIO; [31] request toggle, [30:27] opcode, [26:23] param, [22:8] addr, [7:0] data.
REQ-005 SHALL have port status_out  output  32  to HPS input PIO; [31] ack toggle, [30] error, [29] busy, [23:16] completed-instruction count, [7:0] result, all other bits 0.
REQ-006 SHALL have port cmd_valid  output  1  command to filter core valid.
REQ-007 SHALL have port cmd_ready  input  1  core accepts command.
REQ-008 SHALL have ports cmd_op (output, 2), cmd_param (output, 4), cmd_addr (output, 15), cmd_data (output, 8): registered command fields.
REQ-009 SHALL have ports rsp_valid (input, 1), rsp_data (input, 8), rsp_error (input, 1): one-cycle core response.

Function
REQ-010 SHALL implement FSM states IDLE, DECODE, ISSUE, WAIT, COMPLETE.
REQ-011 IDLE: when instr_in[31] != last_tog, SHALL capture instr_in into instr_reg, set last_tog=instr_in[31], set busy=1, go DECODE; else stay.
REQ-012 DECODE: opcode 0 (NOP) -> COMPLETE, result 0x00, error 0; opcodes 1 LOAD, 2 STORE, 3 FILTER -> ISSUE with cmd_op=opcode[1:0]; opcodes 4-15 -> COMPLETE, result 0x00, error 1.
REQ-013 ISSUE: cmd_valid SHALL be 1 and cmd_* fields SHALL hold instr_reg values unchanged until the cycle cmd_valid&&cmd_ready, then cmd_valid=0 next cycle, timeout counter cleared, go WAIT.
REQ-014 WAIT: rsp_valid=1 -> result=rsp_data, error=rsp_error, go COMPLETE.
REQ-015 WAIT: counter increments each cycle without rsp_valid; on reaching TIMEOUT_CYCLES -> result 0xFF, error 1, go COMPLETE; rsp_valid in the same cycle SHALL take priority over timeout.
REQ-016 No timeout in ISSUE; stall on cmd_ready=0 is unbounded.
REQ-017 COMPLETE: one cycle; status_out SHALL update: [31]=last_tog, [30]=error, [29]=0, [7:0]=result, [23:16]=count+1 (8-bit wrap 255->0); go IDLE.
REQ-018 status_out[29] SHALL be 1 from the edge leaving IDLE through the edge leaving COMPLETE; [31],[30],[7:0] SHALL hold previous values while busy.
REQ-019 instr_in changes while not IDLE SHALL be ignored; toggle comparison resumes in IDLE, so one pending toggle is accepted immediately after COMPLETE; an even number of toggles while busy SHALL yield no new instruction.
REQ-020 rsp_valid outside WAIT SHALL be ignored.
REQ-021 Latency: NOP/illegal status visible 3 cycles after the sampling edge; issued command cmd_valid visible 2 cycles after the sampling edge.

Reset
REQ-022 reset=1 at a clock edge SHALL force IDLE, last_tog=0, status_out=0, count=0, cmd_valid=0, cmd_* fields=0, timeout counter=0, from any state including ISSUE/WAIT (in-flight command abandoned, no status update).
REQ-023 After reset, if instr_in[31]=1, it SHALL be accepted as a new instruction on the first IDLE cycle.

Verification
REQ-024 instr_in=0x80000000 (NOP) after reset -> 3 cycles later status_out=0x80010000, cmd_valid never asserted.
REQ-025 instr_in toggle with opcode 1, addr 0x1234, data 0x5A, cmd_ready low 5 cycles -> cmd_valid held 6 cycles with cmd_op=1, cmd_addr=0x1234, cmd_data=0x5A stable; rsp_valid with rsp_data=0x3C -> status [7:0]=0x3C, [30]=0, [29]=0.
REQ-026 opcode 9 -> status [30]=1, [7:0]=0x00, ack toggle matches, no command issued.
REQ-027 TIMEOUT_CYCLES=16, core accepts but never responds -> status [30]=1, [7:0]=0xFF after 16 WAIT cycles; repeat with rsp_valid on cycle 16 -> response data wins, error 0.
REQ-028 Toggle twice during WAIT -> no second command; toggle once during WAIT -> second command issued right after COMPLETE; reset asserted in WAIT -> status_out=0, cmd_valid=0 next cycle.
REQ-029 256 NOPs -> count field wraps to 0x00.
